// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - instruction queue between fetch and decode with flush
module fetch_decode_queue #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 64,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     i_clk,
    input  logic                     i_arstn,
    input  logic                     i_flush,
    input  logic                     i_fetch_valid,
    input  logic [31:0]              i_fetch_instr,
    input  logic [ADDR_W-1:0]        i_fetch_pc,
    output logic                     o_fetch_ready,
    output logic                     o_dec_valid,
    output logic [31:0]              o_dec_instr,
    output logic [ADDR_W-1:0]        o_dec_pc,
    output logic [6:0]               o_dec_op,
    output logic [2:0]               o_dec_func3,
    output logic                     o_dec_func7_5,
    output logic                     o_dec_instr_25,
    input  logic                     i_dec_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    // Ready depends only on registered occupancy, so a full queue never
    // takes a push in the same cycle it pops.
    assign o_fetch_ready = (count != CNT_W'(DEPTH));
    assign o_dec_valid   = (count != '0);
    assign push          = i_fetch_valid & o_fetch_ready;
    assign pop           = i_dec_ready & o_dec_valid;
    assign o_count       = count;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) begin
            instr_mem[wr_ptr] <= i_fetch_instr;
            pc_mem[wr_ptr]    <= i_fetch_pc;
        end
    end

    always_comb begin
        o_dec_instr = NOP_INSTR;
        o_dec_pc    = '0;
        if (o_dec_valid) begin
            o_dec_instr = instr_mem[rd_ptr];
            o_dec_pc    = pc_mem[rd_ptr];
        end
    end

    assign o_dec_op       = o_dec_instr[6:0];
    assign o_dec_func3    = o_dec_instr[14:12];
    assign o_dec_func7_5  = o_dec_instr[30];
    assign o_dec_instr_25 = o_dec_instr[25];

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - directed self-checking bench for fetch_decode_queue
module tb_fetch_decode_queue;

    logic        clk = 1'b0;
    logic        arstn;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [63:0] fetch_pc;
    logic        fetch_ready;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic [6:0]  dec_op;
    logic [2:0]  dec_func3;
    logic        dec_func7_5;
    logic        dec_instr_25;
    logic        dec_ready;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_decode_queue #(.DEPTH(4), .ADDR_W(64), .NOP_INSTR(32'h0000_0013)) dut (
        .i_clk          (clk),
        .i_arstn        (arstn),
        .i_flush        (flush),
        .i_fetch_valid  (fetch_valid),
        .i_fetch_instr  (fetch_instr),
        .i_fetch_pc     (fetch_pc),
        .o_fetch_ready  (fetch_ready),
        .o_dec_valid    (dec_valid),
        .o_dec_instr    (dec_instr),
        .o_dec_pc       (dec_pc),
        .o_dec_op       (dec_op),
        .o_dec_func3    (dec_func3),
        .o_dec_func7_5  (dec_func7_5),
        .o_dec_instr_25 (dec_instr_25),
        .i_dec_ready    (dec_ready),
        .o_count        (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 64'(dec_valid), 64'd0);
        chk({tag, "_instr"}, 64'(dec_instr), 64'h13);
        chk({tag, "_pc"},    dec_pc,         64'd0);
        chk({tag, "_count"}, 64'(count),     64'd0);
        chk({tag, "_ready"}, 64'(fetch_ready), 64'd1);
    endtask

    initial begin
        arstn       = 1'b0;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        fetch_instr = '0;
        fetch_pc    = '0;
        dec_ready   = 1'b0;
        #2;
        chk_empty("rst");
        #10;
        arstn = 1'b1;
        step();
        chk_empty("post_rst");

        // Single push, no same-cycle bypass
        fetch_valid = 1'b1; fetch_instr = 32'h0050_0093; fetch_pc = 64'h1000;
        #1;
        chk("s1_no_bypass", 64'(dec_valid), 64'd0);
        step();
        fetch_valid = 1'b0;
        chk("s1_valid", 64'(dec_valid), 64'd1);
        chk("s1_op",    64'(dec_op),    64'h13);
        chk("s1_f3",    64'(dec_func3), 64'd0);
        chk("s1_pc",    dec_pc,         64'h1000);
        chk("s1_count", 64'(count),     64'd1);
        chk("s1_instr", 64'(dec_instr), 64'h0050_0093);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        chk_empty("s1_drain");

        // Fill to DEPTH, overflow push ignored, no push on pop when full
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1'b1; fetch_instr = 32'h0000_0093 | (32'(i) << 20); fetch_pc = 64'(i * 4);
            step();
        end
        chk("s2_full_count", 64'(count),       64'd4);
        chk("s2_full_ready", 64'(fetch_ready), 64'd0);
        chk("s2_full_head",  dec_pc,           64'h0);
        fetch_pc = 64'h10; fetch_instr = 32'hdead_0013;
        step();
        chk("s2_ovf_count", 64'(count), 64'd4);
        chk("s2_ovf_head",  dec_pc,     64'h0);
        dec_ready = 1'b1;
        step();
        fetch_valid = 1'b0;
        chk("s2_popfull_count", 64'(count), 64'd3);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("s2_head%0d", i), dec_pc, 64'(i * 4));
            step();
        end
        dec_ready = 1'b0;
        chk("s2_end_valid", 64'(dec_valid), 64'd0);
        chk("s2_end_instr", 64'(dec_instr), 64'h13);

        // Streaming at count 1 across pointer wrap
        fetch_valid = 1'b1; fetch_pc = 64'h100; fetch_instr = 32'h0000_0113;
        step();
        chk("s3_count0", 64'(count), 64'd1);
        dec_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            fetch_pc = 64'h104 + 64'(4 * k);
            chk($sformatf("s3_head%0d", k), dec_pc, 64'h100 + 64'(4 * k));
            step();
            chk($sformatf("s3_count%0d", k + 1), 64'(count), 64'd1);
        end
        fetch_valid = 1'b0;
        chk("s3_last", dec_pc, 64'h128);
        step();
        dec_ready = 1'b0;
        chk("s3_drain_count", 64'(count), 64'd0);

        // Flush with a coincident push
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1; fetch_pc = 64'h300 + 64'(4 * i);
            step();
        end
        chk("s4_pre_count", 64'(count), 64'd3);
        flush = 1'b1; fetch_pc = 64'h2000;
        step();
        flush = 1'b0; fetch_valid = 1'b0;
        chk_empty("s4_flush");
        step();
        chk("s4_still_empty", 64'(count), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("s4_flush_empty", 64'(count), 64'd0);
        fetch_valid = 1'b1; fetch_pc = 64'h400;
        step();
        fetch_valid = 1'b0;
        chk("s4_after_pc",    dec_pc,     64'h400);
        chk("s4_after_count", 64'(count), 64'd1);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;

        // Field slicing: SUB then MUL, head holds while stalled
        fetch_valid = 1'b1; fetch_instr = 32'h4020_8033; fetch_pc = 64'h500;
        step();
        fetch_instr = 32'h0220_8033; fetch_pc = 64'h504;
        step();
        fetch_valid = 1'b0;
        chk("s5_sub_op",  64'(dec_op),       64'h33);
        chk("s5_sub_f3",  64'(dec_func3),    64'd0);
        chk("s5_sub_f75", 64'(dec_func7_5),  64'd1);
        chk("s5_sub_b25", 64'(dec_instr_25), 64'd0);
        step();
        chk("s5_hold_instr", 64'(dec_instr), 64'h4020_8033);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        chk("s5_mul_op",  64'(dec_op),       64'h33);
        chk("s5_mul_f75", 64'(dec_func7_5),  64'd0);
        chk("s5_mul_b25", 64'(dec_instr_25), 64'd1);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;

        // Asynchronous reset mid-cycle with entries queued
        fetch_valid = 1'b1; fetch_pc = 64'h600;
        step();
        fetch_pc = 64'h604;
        step();
        fetch_valid = 1'b0;
        chk("s6_pre_count", 64'(count), 64'd2);
        #2;
        arstn = 1'b0;
        #1;
        chk_empty("s6_async");
        #2;
        arstn = 1'b1;
        step();
        fetch_valid = 1'b1; fetch_instr = 32'h0050_0093; fetch_pc = 64'h1000;
        step();
        fetch_valid = 1'b0;
        chk("s6_re_pc",    dec_pc,      64'h1000);
        chk("s6_re_op",    64'(dec_op), 64'h13);
        chk("s6_re_count", 64'(count),  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Small instruction queue between the fetch unit and the decode stage.
- Decouples fetch from decode stalls.
- Presents the head instruction, its PC, and the pre-sliced opcode/func fields consumed by the control unit.
- Supports pipeline flush on redirect (branch/jump/trap): the queue drops everything in one cycle, and decode sees a NOP.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- ADDR_W, 64, PC width.
- NOP_INSTR, 32'h0000_0013, encoding driven on o_dec_instr when the queue is empty (addi x0,x0,0).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_arstn  input  1  asynchronous active-low reset.
- i_flush  input  1  redirect/flush request from execute or trap logic.
- i_fetch_valid  input  1  fetch presents a valid instruction.
- i_fetch_instr  input  32  fetched instruction word.
- i_fetch_pc  input  ADDR_W  PC of the fetched instruction.
- o_fetch_ready  output  1  queue can accept a push this cycle.
- o_dec_valid  output  1  head entry valid.
- o_dec_instr  output  32  head instruction, or NOP_INSTR when empty.
- o_dec_pc  output  ADDR_W  head PC, or 0 when empty.
- o_dec_op  output  7  o_dec_instr[6:0].
- o_dec_func3  output  3  o_dec_instr[14:12].
- o_dec_func7_5  output  1  o_dec_instr[30].
- o_dec_instr_25  output  1  o_dec_instr[25].
- i_dec_ready  input  1  decode consumes the head this cycle (stall = 0).
- o_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (i_arstn = 0, asynchronous):
  - Read pointer, write pointer and count go to 0; all entries are marked invalid.
  - Outputs during and after reset: o_dec_valid = 0, o_dec_instr = NOP_INSTR, o_dec_pc = 0, o_count = 0, o_fetch_ready = 1.
  - Entry data contents need no reset.
- Storage and pointers:
  - Circular buffer of DEPTH entries, each holding {instr, pc}.
  - Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - Occupancy is tracked in the explicit count register, not inferred from pointers.
- Push and pop conditions:
  - push = i_fetch_valid & o_fetch_ready.
  - pop = i_dec_ready & o_dec_valid.
  - o_fetch_ready = (count != DEPTH). It is registered-state only: there is no combinational path from i_dec_ready, so a full queue does not accept a push in the same cycle as a pop.
- Latency and head outputs:
  - A pushed entry becomes visible at the head on the next cycle at the earliest. There is no same-cycle bypass, including when the queue is empty.
  - o_dec_valid = (count != 0).
  - o_dec_instr, o_dec_pc and the field slices are read combinationally from the head entry. When the queue is empty they are forced to NOP_INSTR / 0.
- Count update each cycle:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop together: count unchanged, both pointers advance.
  - neither: hold.
- Flush:
  - i_flush has priority over push and pop in the same cycle.
  - On the next edge: count = 0, rd_ptr = wr_ptr = 0, and any push presented in the flush cycle is discarded.
  - In the cycle after a flush: o_dec_valid = 0 and o_dec_instr = NOP_INSTR.
  - Flush while already empty: no effect beyond the pointer reset.
- Holding behaviour:
  - While i_dec_ready = 0, the head outputs hold stable.
  - Fetch may continue pushing until the queue is full.
- Reset mid-operation:
  - Asserting i_arstn low at any time clears the queue immediately and asynchronously.
  - Deasserting it resumes in the empty state.
- Illegal stimulus:
  - i_fetch_valid asserted while o_fetch_ready = 0 is legal. It is ignored, and fetch must hold the instruction and retry.

Test Plan:
1. Reset, then a single push of instr 32'h00500093, pc 0x1000, with i_dec_ready = 0 → next cycle o_dec_valid = 1, o_dec_op = 7'h13, o_dec_func3 = 0, o_dec_pc = 0x1000, o_count = 1.
2. Fill DEPTH = 4 with pcs 0x0, 0x4, 0x8, 0xC while i_dec_ready = 0 → o_count = 4, o_fetch_ready = 0; a fifth push of pc 0x10 is ignored. Then assert i_dec_ready for 4 cycles → heads 0x0, 0x4, 0x8, 0xC in order, then o_dec_valid = 0 and o_dec_instr = 32'h00000013.
3. Continuous streaming with push and pop every cycle for 10 cycles at count = 1 → count stays 1, PCs emerge in order across pointer wrap-around, no loss or duplication.
4. Queue holding 3 entries, then i_flush = 1 together with a push of pc 0x2000 → next cycle o_count = 0, o_dec_valid = 0, and pc 0x2000 never appears at the head.
5. Push an R-type SUB 32'h40208033 → o_dec_op = 7'h33, o_dec_func3 = 0, o_dec_func7_5 = 1, o_dec_instr_25 = 0. Push MUL 32'h02208033 → o_dec_instr_25 = 1, o_dec_func7_5 = 0.
6. Drive i_arstn low asynchronously mid-clock with 2 entries queued → outputs immediately show o_dec_valid = 0, o_count = 0, o_fetch_ready = 1. After release, a push behaves as in scenario 1.
